// File: rtl/rvvi_reply_monitor.sv
// rvvi_reply_monitor: parses 7-beat RVVI reply frames from the MAC RX stream,
// publishes the host's acknowledged minstret/load and drives the inflight stall.
module rvvi_reply_monitor #(
    parameter logic [15:0] ETHER_TYPE      = 16'h88B5,
    parameter logic [31:0] MAX_INFLIGHT    = 32'd64,
    parameter logic [31:0] RESUME_INFLIGHT = 32'd32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] RvviAxiRdata,
    input  logic [3:0]  RvviAxiRstrb,
    input  logic        RvviAxiRvalid,
    input  logic        RvviAxiRlast,
    input  logic [63:0] LocalMinstret,
    output logic [63:0] AckMinstret,
    output logic [31:0] HostLoad,
    output logic        AckValid,
    output logic [7:0]  BadFrameCount,
    output logic        ExternalStall
);
    typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;

    state_t      state_q;
    logic [2:0]  beat_q;
    logic        type_ok_q;
    logic [63:0] mst_q;
    logic [15:0] load_q;
    logic [63:0] ack_q;
    logic [31:0] host_q;
    logic        ack_valid_q;
    logic [7:0]  bad_q;
    logic        stall_q;

    logic        final_beat_d;
    logic        accept_d;
    logic        bad_d;
    logic [63:0] inflight_d;
    logic        stall_d;

    // Beat w6 decides the frame: anything but a clean, in-order accept is bad.
    assign final_beat_d = state_q == RECV && beat_q == 3'd6;
    assign accept_d     = RvviAxiRvalid && final_beat_d && RvviAxiRlast && RvviAxiRstrb == 4'hF
                          && type_ok_q && mst_q >= ack_q;
    assign bad_d        = RvviAxiRvalid && ((state_q == IDLE && RvviAxiRlast)
                          || (state_q == RECV && (final_beat_d ? !accept_d : RvviAxiRlast)));
    assign inflight_d   = LocalMinstret - ack_q;
    assign stall_d      = inflight_d >= {32'd0, MAX_INFLIGHT} ? 1'b1 :
                          inflight_d <= {32'd0, RESUME_INFLIGHT} ? 1'b0 : stall_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            type_ok_q   <= 1'b0;
            mst_q       <= '0;
            load_q      <= '0;
            ack_q       <= '0;
            host_q      <= '0;
            ack_valid_q <= 1'b0;
            bad_q       <= '0;
            stall_q     <= 1'b0;
        end else begin
            ack_valid_q <= accept_d;
            stall_q     <= stall_d;
            if (bad_d && bad_q != 8'hFF) bad_q <= bad_q + 8'd1;
            if (accept_d) begin
                ack_q  <= mst_q;
                host_q <= {RvviAxiRdata[15:0], load_q};
            end
            if (RvviAxiRvalid) begin
                case (state_q)
                    IDLE: if (!RvviAxiRlast) begin
                        state_q <= RECV;
                        beat_q  <= 3'd1;
                    end
                    RECV: begin
                        beat_q <= beat_q + 3'd1;
                        if (beat_q == 3'd3) begin
                            type_ok_q   <= RvviAxiRdata[15:0] == ETHER_TYPE;
                            mst_q[15:0] <= RvviAxiRdata[31:16];
                        end
                        if (beat_q == 3'd4) mst_q[47:16] <= RvviAxiRdata;
                        if (beat_q == 3'd5) begin
                            mst_q[63:48] <= RvviAxiRdata[15:0];
                            load_q       <= RvviAxiRdata[31:16];
                        end
                        if (RvviAxiRlast || final_beat_d) begin
                            beat_q  <= '0;
                            state_q <= RvviAxiRlast ? IDLE : DROP;
                        end
                    end
                    default: if (RvviAxiRlast) state_q <= IDLE;
                endcase
            end
        end
    end

    assign AckMinstret   = ack_q;
    assign HostLoad      = host_q;
    assign AckValid      = ack_valid_q;
    assign BadFrameCount = bad_q;
    assign ExternalStall = stall_q;
endmodule

// File: tb/tb_rvvi_reply_monitor.sv
// tb_rvvi_reply_monitor: directed and random reply frames checked against a frame-level model.
module tb_rvvi_reply_monitor;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] RvviAxiRdata = '0;
    logic [3:0]  RvviAxiRstrb = '0;
    logic        RvviAxiRvalid = 1'b0;
    logic        RvviAxiRlast = 1'b0;
    logic [63:0] LocalMinstret = '0;
    logic [63:0] AckMinstret;
    logic [31:0] HostLoad;
    logic        AckValid;
    logic [7:0]  BadFrameCount;
    logic        ExternalStall;

    rvvi_reply_monitor dut (
        .clk(clk), .reset_n(reset_n),
        .RvviAxiRdata(RvviAxiRdata), .RvviAxiRstrb(RvviAxiRstrb),
        .RvviAxiRvalid(RvviAxiRvalid), .RvviAxiRlast(RvviAxiRlast),
        .LocalMinstret(LocalMinstret), .AckMinstret(AckMinstret), .HostLoad(HostLoad),
        .AckValid(AckValid), .BadFrameCount(BadFrameCount), .ExternalStall(ExternalStall)
    );

    always #5 clk = ~clk;

    int pulses = 0;
    always @(negedge clk) if (AckValid === 1'b1) pulses++;

    int checks = 0;
    int failures = 0;
    logic [31:0] frame [0:9];
    logic [63:0] m_ack = '0;
    logic [31:0] m_load = '0;
    int          m_bad = 0;
    int          m_acks = 0;
    logic        m_stall = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic build(input logic [15:0] typ, input logic [63:0] mst, input logic [31:0] load);
        for (int i = 0; i < 10; i++) frame[i] = $urandom;
        frame[3] = {mst[15:0], typ};
        frame[4] = mst[47:16];
        frame[5] = {load[15:0], mst[63:48]};
        frame[6] = {frame[6][31:16], load[31:16]};
    endtask

    task automatic send(input int len, input logic [3:0] strb, input int gap);
        for (int i = 0; i < len; i++) begin
            RvviAxiRdata  = frame[i];
            RvviAxiRstrb  = (i == len - 1) ? strb : 4'($urandom);
            RvviAxiRlast  = (i == len - 1);
            RvviAxiRvalid = 1'b1;
            @(posedge clk); #1;
            RvviAxiRvalid = 1'b0;
            RvviAxiRlast  = 1'b0;
            if (i < len - 1 && gap > 0) begin
                repeat ($urandom_range(0, gap)) @(posedge clk);
                #1;
            end
        end
    endtask

    // Frame-level rules: exactly 7 beats, full keep, right type, non-decreasing minstret.
    task automatic model(input int len, input logic [3:0] strb, input logic [15:0] typ,
                         input logic [63:0] mst, input logic [31:0] load);
        if (len == 7 && strb == 4'hF && typ == 16'h88B5 && mst >= m_ack) begin
            m_ack = mst;
            m_load = load;
            m_acks++;
        end else if (m_bad < 255) m_bad++;
    endtask

    task automatic upd_stall();
        logic [63:0] infl;
        infl = LocalMinstret - m_ack;
        if (infl >= 64) m_stall = 1'b1;
        else if (infl <= 32) m_stall = 1'b0;
    endtask

    task automatic settle_check(input string tag);
        repeat (2) @(posedge clk);
        #1;
        upd_stall();
        chk({tag, ".ack"}, AckMinstret, m_ack);
        chk({tag, ".load"}, {32'd0, HostLoad}, {32'd0, m_load});
        chk({tag, ".bad"}, {56'd0, BadFrameCount}, 64'(m_bad));
        chk({tag, ".pulses"}, 64'(pulses), 64'(m_acks));
        chk({tag, ".stall"}, {63'd0, ExternalStall}, {63'd0, m_stall});
    endtask

    task automatic do_frame(input string tag, input int len, input logic [3:0] strb,
                            input logic [15:0] typ, input logic [63:0] mst,
                            input logic [31:0] load, input int gap);
        build(typ, mst, load);
        send(len, strb, gap);
        model(len, strb, typ, mst, load);
        settle_check(tag);
    endtask

    initial begin
        logic [63:0] mst;
        logic [15:0] typ;
        int kind, len;
        logic [3:0] strb;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.ack", AckMinstret, 64'd0);
        chk("rst.load", {32'd0, HostLoad}, 64'd0);
        chk("rst.valid", {63'd0, AckValid}, 64'd0);
        chk("rst.bad", {56'd0, BadFrameCount}, 64'd0);
        chk("rst.stall", {63'd0, ExternalStall}, 64'd0);
        reset_n = 1'b1;
        LocalMinstret = 64'd1;
        @(posedge clk); #1;

        frame[0] = 32'h1111_2222; frame[1] = 32'h3333_4444; frame[2] = 32'h5555_6666;
        frame[3] = 32'h0001_88B5; frame[4] = 32'h0000_0000;
        frame[5] = 32'h0005_0000; frame[6] = 32'h0000_0000;
        send(7, 4'hF, 0);
        model(7, 4'hF, 16'h88B5, 64'd1, 32'd5);
        settle_check("good");
        chk("good.load5", {32'd0, HostLoad}, 64'd5);

        do_frame("wrongtype", 7, 4'hF, 16'h0800, 64'd2, 32'd7, 0);
        do_frame("short5", 5, 4'hF, 16'h88B5, 64'd3, 32'd7, 0);
        do_frame("long9", 9, 4'hF, 16'h88B5, 64'd4, 32'd7, 0);
        do_frame("after9", 7, 4'hF, 16'h88B5, 64'd5, 32'h1234_5678, 0);
        do_frame("gaps", 7, 4'hF, 16'h88B5, 64'd6, 32'hCAFE_0001, 3);
        do_frame("badstrb", 7, 4'h7, 16'h88B5, 64'd7, 32'd9, 0);

        build(16'h88B5, 64'd999, 32'd1);
        send(4, 4'hF, 0);
        RvviAxiRdata = frame[4];
        RvviAxiRvalid = 1'b1;
        LocalMinstret = 64'd0;
        #2 reset_n = 1'b0;
        #1;
        chk("midrst.ack", AckMinstret, 64'd0);
        chk("midrst.bad", {56'd0, BadFrameCount}, 64'd0);
        chk("midrst.load", {32'd0, HostLoad}, 64'd0);
        @(posedge clk); #1;
        RvviAxiRvalid = 1'b0;
        reset_n = 1'b1;
        m_ack = '0; m_load = '0; m_bad = 0; m_stall = 1'b0;
        @(posedge clk); #1;
        chk("postrst.stall", {63'd0, ExternalStall}, 64'd0);
        chk("postrst.valid", {63'd0, AckValid}, 64'd0);

        LocalMinstret = 64'd64;
        settle_check("stall64");
        chk("stall64.on", {63'd0, ExternalStall}, 64'd1);
        build(16'h88B5, 64'd40, 32'd77);
        send(7, 4'hF, 0);
        chk("ack40.pulse", {63'd0, AckValid}, 64'd1);
        chk("ack40.stall_hold", {63'd0, ExternalStall}, 64'd1);
        @(posedge clk); #1;
        chk("ack40.stall_off", {63'd0, ExternalStall}, 64'd0);
        model(7, 4'hF, 16'h88B5, 64'd40, 32'd77);
        settle_check("ack40");
        LocalMinstret = 64'd90;
        settle_check("infl50");
        chk("infl50.off", {63'd0, ExternalStall}, 64'd0);
        do_frame("stale10", 7, 4'hF, 16'h88B5, 64'd10, 32'd3, 0);
        chk("stale10.ack", AckMinstret, 64'd40);

        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 6);
            len = 7; strb = 4'hF; typ = 16'h88B5;
            mst = m_ack + 64'($urandom_range(0, 40));
            if (kind == 2) typ = 16'($urandom_range(0, 16'h88B4));
            if (kind == 3) len = $urandom_range(1, 6);
            if (kind == 4) len = $urandom_range(8, 10);
            if (kind == 5) strb = 4'($urandom_range(0, 14));
            if (kind == 6) mst = m_ack - 64'($urandom_range(1, 20));
            LocalMinstret = m_ack + 64'($urandom_range(0, 100));
            repeat (2) @(posedge clk);
            #1;
            upd_stall();
            do_frame("rand", len, strb, typ, mst, $urandom, 3);
        end

        for (int n = 0; n < 300; n++) begin
            build(16'h88B5, m_ack, 32'd0);
            send(1, 4'hF, 0);
            model(1, 4'hF, 16'h88B5, m_ack, 32'd0);
        end
        settle_check("sat");
        chk("sat.ff", {56'd0, BadFrameCount}, 64'hFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rvvi_reply_monitor.md
RVVI_REPLY_MONITOR -- requirements
Module: rvvi_reply_monitor

Interface
REQ-001 Parameter: ETHER_TYPE, 16'h88B5, required value of the reply frame type field.
REQ-002 Parameter: MAX_INFLIGHT, 32'd64, unacknowledged-instruction count that asserts ExternalStall.
REQ-003 Parameter: RESUME_INFLIGHT, 32'd32, count at or below which ExternalStall deasserts; must be less than MAX_INFLIGHT.
REQ-004 Port: clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-006 Port: RvviAxiRdata  input  32  receive AXI-stream data from the Ethernet MAC RX FIFO.
REQ-007 Port: RvviAxiRstrb  input  4  byte keep; ignored except that the final beat must be 4'hF.
REQ-008 Port: RvviAxiRvalid  input  1  beat valid; the MAC sink is always ready, so every valid beat is consumed.
REQ-009 Port: RvviAxiRlast  input  1  last beat of frame.
REQ-010 Port: LocalMinstret  input  64  core retired-instruction count (counter index 2).
REQ-011 Port: AckMinstret  output  64  minstret from the most recent accepted reply.
REQ-012 Port: HostLoad  output  32  host load estimate from the most recent accepted reply.
REQ-013 Port: AckValid  output  1  one-cycle pulse when AckMinstret/HostLoad update.
REQ-014 Port: BadFrameCount  output  8  saturating count of rejected frames.
REQ-015 Port: ExternalStall  output  1  stall request to the core.

Function
REQ-016 Frame layout: exactly 7 beats, w0..w6; w0-w2 MAC addresses (ignored); w3[15:0] type; minstret = {w5[15:0], w4, w3[31:16]}; load = {w6[15:0], w5[31:16]}; w6[31:16] ignored.
REQ-017 FSM states: IDLE, RECV, DROP; reset state IDLE.
REQ-018 IDLE: a valid beat without last moves to RECV with beat index 1; a valid beat with last is a bad frame and the FSM stays in IDLE.
REQ-019 RECV: each valid beat increments the 3-bit beat index; cycles with Rvalid low hold all state with no timeout.
REQ-020 RECV: last on beats w1..w5 is a bad frame; the FSM returns to IDLE.
REQ-021 RECV: beat w6 without last is a bad frame; the FSM moves to DROP.
REQ-022 DROP: discard beats until a valid last, then return to IDLE; a bad frame counts once, at the transition into DROP.
REQ-023 Type check: w3[15:0] is registered at w3; a mismatch marks the frame bad, counted at its end, with no update.
REQ-024 A frame is accepted when w6 carries last, Rstrb is 4'hF, the type matches, and the assembled minstret is greater than or equal to (unsigned) the current AckMinstret.
REQ-025 Acceptance: AckMinstret, HostLoad and AckValid update on the edge that consumes w6, which is 1 cycle after the final beat is presented.
REQ-026 A stale (smaller) minstret is a bad frame.
REQ-027 Partial fields are held in shadow registers, so the outputs never show mixed frames.
REQ-028 BadFrameCount increments by 1 per bad frame and saturates at 8'hFF.
REQ-029 InFlight = LocalMinstret - AckMinstret, a 64-bit modulo subtraction compared unsigned against the zero-extended parameters.
REQ-030 ExternalStall is registered: it sets when InFlight >= MAX_INFLIGHT and clears when InFlight <= RESUME_INFLIGHT; otherwise it holds (hysteresis).
REQ-031 ExternalStall uses the AckMinstret value from the same cycle, so an acceptance affects the stall 1 cycle after AckValid.

Reset
REQ-032 Asserting reset_n low at any time, including mid-frame, immediately forces IDLE, beat index 0, all outputs 0, and clears the shadow registers.
REQ-033 After reset_n deasserts, a partially received frame continues as if new: its first subsequent beat is treated as w0.

Verification
REQ-034 Good frame: w3=32'h0001_88B5, w4=32'h0000_0000, w5=32'h0005_0000, w6=32'h0000_0000, last on w6 -> AckMinstret=64'h0000_0000_0000_0001, HostLoad=32'h0000_0005, one AckValid pulse, BadFrameCount=0.
REQ-035 Wrong type 16'h0800 -> no AckValid, BadFrameCount=1; 5-beat frame -> BadFrameCount=2; 9-beat frame -> BadFrameCount=3, and the FSM reaches IDLE only after beat 9.
REQ-036 Rvalid gaps of 0-3 random cycles inside a good frame -> same result as the gapless case.
REQ-037 LocalMinstret=64, AckMinstret=0 -> ExternalStall=1; accept minstret 40 (InFlight 24) -> ExternalStall=0 one cycle after AckValid; InFlight at 50 -> stays 0.
REQ-038 Stale minstret 10 after an accepted 40 -> AckMinstret stays 40 and BadFrameCount increments; 300 bad frames -> BadFrameCount=8'hFF.
REQ-039 reset_n low during w4 of a frame, then a full good frame -> only the good frame is accepted, and all outputs are 0 before it.
